// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
//   Shares one cache request/response port between two CPU-side requesters.
//   Round-robin arbitration loads a one-entry output register to the cache.
//   An in-order tag FIFO remembers which port issued each read, so every read
//   response is steered back to the port that issued it.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   reqN_pkt_i                 request packet {addr, wdata, wstrb, we}, we = bit 0
//   reqN_valid_i/reqN_ready_o  request handshake, port N (N = 0, 1)
//   cache_pkt_o/cache_valid_o  registered packet to the cache
//   cache_ready_i              cache accepts the packet
//   cache_data_i/cache_valid_i read response from the cache (strobe, no backpressure)
//   cache_ready_o              a response can be absorbed (tag pending, sink ready)
//   rspN_data_o/rspN_valid_o   read response to port N
//   rspN_ready_i               port N response sink not full
//   rsp_err_o                  sticky: response arrived with no read outstanding
module cache_req_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BYTES     = 4,
  parameter int FIFO_WIDTH     = 69,
  parameter int RD_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FIFO_WIDTH-1:0] req0_pkt_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [FIFO_WIDTH-1:0] req1_pkt_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  output logic [FIFO_WIDTH-1:0] cache_pkt_o,
  output logic                  cache_valid_o,
  input  logic                  cache_ready_i,
  input  logic [DATA_WIDTH-1:0] cache_data_i,
  input  logic                  cache_valid_i,
  output logic                  cache_ready_o,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic                  rsp_err_o
);

  // Output register is sized from the packet fields it carries.
  localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH + DATA_BYTES + 1;
  localparam int PTR_W = $clog2(RD_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic                      stage_vld_q, stage_vld_d;
  logic [PKT_W-1:0]          stage_pkt_q, stage_pkt_d;
  logic                      last_grant_q, last_grant_d;
  logic [RD_OUTSTANDING-1:0] tag_mem_q, tag_mem_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic                      err_q, err_d;

  logic                  stage_free, rd_full, tag_empty;
  logic                  elig0, elig1, grant0, grant1, grant_any;
  logic [FIFO_WIDTH-1:0] grant_pkt;
  logic                  push, pop, head;

  always_comb begin
    stage_free = !stage_vld_q || cache_ready_i;
    rd_full    = (rd_cnt_q == CNT_W'(RD_OUTSTANDING));
    tag_empty  = (rd_cnt_q == '0);

    // Writes are never blocked; reads wait while every tag slot is in use.
    elig0 = req0_valid_i && (req0_pkt_i[0] || !rd_full);
    elig1 = req1_valid_i && (req1_pkt_i[0] || !rd_full);

    grant0 = 1'b0;
    grant1 = 1'b0;
    if (stage_free) begin
      if (elig0 && elig1) begin
        // last_grant_q holds the port ID granted last; the other one wins.
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
    grant_any = grant0 || grant1;
    grant_pkt = grant1 ? req1_pkt_i : req0_pkt_i;

    // Tag is recorded at the grant edge, so ordering matches grant order.
    push = grant_any && !grant_pkt[0];
    head = tag_mem_q[rd_ptr_q];
    pop  = cache_valid_i && !tag_empty;

    stage_vld_d = stage_vld_q;
    if (stage_vld_q && cache_ready_i) stage_vld_d = 1'b0;
    if (grant_any) stage_vld_d = 1'b1;
    stage_pkt_d  = grant_any ? grant_pkt : stage_pkt_q;
    last_grant_d = grant_any ? grant1 : last_grant_q;

    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = grant1;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase

    // A response with nothing outstanding is dropped and latched as an error.
    err_d = err_q || (cache_valid_i && tag_empty);
  end

  assign req0_ready_o  = grant0 && !rst_i;
  assign req1_ready_o  = grant1 && !rst_i;
  assign cache_pkt_o   = stage_pkt_q;
  assign cache_valid_o = stage_vld_q;
  assign cache_ready_o = !tag_empty && (head ? rsp1_ready_i : rsp0_ready_i);
  assign rsp0_valid_o  = pop && !head;
  assign rsp1_valid_o  = pop && head;
  assign rsp0_data_o   = cache_data_i;
  assign rsp1_data_o   = cache_data_i;
  assign rsp_err_o     = err_q;

  // Control state: reset returns the arbiter to empty with port 0 first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_vld_q  <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
    end
  end

  // Data storage: contents are only meaningful under the valid/count state.
  always_ff @(posedge clk_i) begin
    stage_pkt_q <= stage_pkt_d;
    tag_mem_q   <= tag_mem_d;
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DB = 4;
  localparam int FW = 69;
  localparam int RO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] req0_pkt, req1_pkt, cache_pkt;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic          cache_valid_o, cache_ready_i, cache_valid_i, cache_ready_o;
  logic [DW-1:0] cache_data, rsp0_data, rsp1_data;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp_err;

  int errors = 0;
  int checks = 0;

  cache_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB),
    .FIFO_WIDTH(FW), .RD_OUTSTANDING(RO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_pkt_i(req0_pkt), .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req1_pkt_i(req1_pkt), .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .cache_pkt_o(cache_pkt), .cache_valid_o(cache_valid_o), .cache_ready_i(cache_ready_i),
    .cache_data_i(cache_data), .cache_valid_i(cache_valid_i), .cache_ready_o(cache_ready_o),
    .rsp0_data_o(rsp0_data), .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp1_data_o(rsp1_data), .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mkpkt(input logic [31:0] a, input logic [31:0] d, input logic we);
    return {a, d, 4'hF, we};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_pkt = '0; req1_pkt = '0;
    cache_ready_i = 1'b1; cache_valid_i = 1'b0; cache_data = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_pkt = mkpkt(32'h10, 32'h1, 1'b1);
    req1_valid = 1'b1; req1_pkt = mkpkt(32'h20, 32'h2, 1'b1);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready); end
    step();
    checks++; if (cache_valid_o !== 1'b0) begin errors++; $display("FAIL rst_cache_valid: got %b want 0", cache_valid_o); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cache_ready_o: got %b want 0", cache_ready_o); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_writes();
    logic [FW-1:0] w [3];
    w[0] = mkpkt(32'h1000, 32'h11111111, 1'b1);
    w[1] = mkpkt(32'h1004, 32'h22222222, 1'b1);
    w[2] = mkpkt(32'h1008, 32'h33333333, 1'b1);
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_pkt = w[i];
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready[%0d]: got %b want 1", i, req0_ready); end
      step();
      checks++; if (cache_valid_o !== 1'b1) begin errors++; $display("FAIL wr_valid[%0d]: got %b want 1", i, cache_valid_o); end
      checks++; if (cache_pkt !== w[i]) begin errors++; $display("FAIL wr_pkt[%0d]: got %h want %h", i, cache_pkt, w[i]); end
    end
    req0_valid = 1'b0;
    #1;
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL wr_no_tags: got %b want 0", cache_ready_o); end
    step();
    checks++; if (cache_valid_o !== 1'b0) begin errors++; $display("FAIL wr_drain: got %b want 0", cache_valid_o); end
  endtask

  task automatic test_round_robin();
    logic [FW-1:0] r0, r1;
    int p;
    r0 = mkpkt(32'h100, 32'h0, 1'b0);
    r1 = mkpkt(32'h200, 32'h0, 1'b0);
    do_reset();
    req0_valid = 1'b1; req0_pkt = r0;
    req1_valid = 1'b1; req1_pkt = r1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rr_first_grant0: got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rr_first_grant1: got %b want 0", req1_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      p = i % 2;
      cache_valid_i = 1'b1;
      cache_data = 32'hA0 + 32'(i);
      #1;
      checks++; if (cache_pkt !== (p == 1 ? r1 : r0)) begin errors++; $display("FAIL rr_pkt[%0d]: got %h want %h", i, cache_pkt, (p == 1 ? r1 : r0)); end
      checks++; if (rsp0_valid !== (p == 0)) begin errors++; $display("FAIL rr_rsp0_valid[%0d]: got %b want %b", i, rsp0_valid, (p == 0)); end
      checks++; if (rsp1_valid !== (p == 1)) begin errors++; $display("FAIL rr_rsp1_valid[%0d]: got %b want %b", i, rsp1_valid, (p == 1)); end
      checks++; if ((p == 1 ? rsp1_data : rsp0_data) !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, (p == 1 ? rsp1_data : rsp0_data), 32'hA0 + 32'(i)); end
      checks++; if (req0_ready !== (p == 1)) begin errors++; $display("FAIL rr_next_grant[%0d]: got req0_ready=%b want %b", i, req0_ready, (p == 1)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    cache_valid_i = 1'b0;
    #1;
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL rr_tags_empty: got %b want 0", cache_ready_o); end
    checks++; if (cache_valid_o !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", cache_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] w0, w1;
    w0 = mkpkt(32'h10, 32'h1111, 1'b1);
    w1 = mkpkt(32'h20, 32'h2222, 1'b1);
    do_reset();
    cache_ready_i = 1'b0;
    req0_valid = 1'b1; req0_pkt = w0;
    req1_valid = 1'b1; req1_pkt = w1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_load: got %b want 1", req0_ready); end
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (cache_pkt !== w0) begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", i, cache_pkt, w0); end
      checks++; if (cache_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, cache_valid_o); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); end
      step();
    end
    cache_ready_i = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_resume: got %b want 01", {req0_ready, req1_ready}); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cache_pkt !== (i % 2 == 0 ? w1 : w0)) begin errors++; $display("FAIL bp_flow[%0d]: got %h want %h", i, cache_pkt, (i % 2 == 0 ? w1 : w0)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    checks++; if (cache_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", cache_valid_o); end
  endtask

  task automatic test_rd_block();
    logic [FW-1:0] r1a, r1b, w0;
    r1a = mkpkt(32'h500, 32'h0, 1'b0);
    r1b = mkpkt(32'h504, 32'h0, 1'b0);
    w0  = mkpkt(32'h600, 32'h5A5A, 1'b1);
    do_reset();
    req1_valid = 1'b1; req1_pkt = r1a;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL blk_fill[%0d]: got %b want 1", i, req1_ready); end
      step();
    end
    req1_pkt = r1b;
    req0_valid = 1'b1; req0_pkt = w0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL blk_read_blocked: got %b want 0", req1_ready); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL blk_write_granted: got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    cache_valid_i = 1'b1; cache_data = 32'hB0;
    #1;
    checks++; if (cache_pkt !== w0) begin errors++; $display("FAIL blk_write_pkt: got %h want %h", cache_pkt, w0); end
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin errors++; $display("FAIL blk_rsp_route: got %b want 10", {rsp1_valid, rsp0_valid}); end
    checks++; if (rsp1_data !== 32'hB0) begin errors++; $display("FAIL blk_rsp_data: got %h want b0", rsp1_data); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL blk_still_blocked: got %b want 0", req1_ready); end
    step();
    cache_valid_i = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL blk_unblocked: got %b want 1", req1_ready); end
    step();
    checks++; if (cache_pkt !== r1b) begin errors++; $display("FAIL blk_read_pkt: got %h want %h", cache_pkt, r1b); end
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL blk_full_again: got %b want 0", req1_ready); end
    req1_valid = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL blk_head_sink_full: got %b want 0", cache_ready_o); end
    rsp1_ready = 1'b1; rsp0_ready = 1'b0;
    #1;
    checks++; if (cache_ready_o !== 1'b1) begin errors++; $display("FAIL blk_head_sink_ok: got %b want 1", cache_ready_o); end
    rsp0_ready = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    int p;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      req0_valid = (k < 6) && (k % 2 == 0);
      req1_valid = (k < 6) && (k % 2 == 1);
      req0_pkt = mkpkt(32'h300 + 32'(k), 32'h0, 1'b0);
      req1_pkt = mkpkt(32'h400 + 32'(k), 32'h0, 1'b0);
      cache_valid_i = (k >= 3);
      cache_data = (k >= 3) ? 32'hC0 + 32'(k - 3) : 32'h0;
      #1;
      checks++; if (cache_ready_o !== (k >= 1)) begin errors++; $display("FAIL wrap_cache_ready[%0d]: got %b want %b", k, cache_ready_o, (k >= 1)); end
      if (k < 6) begin
        checks++; if ((k % 2 == 1 ? req1_ready : req0_ready) !== 1'b1) begin errors++; $display("FAIL wrap_grant[%0d]: got 0 want 1", k); end
      end
      if (k >= 3) begin
        p = (k - 3) % 2;
        checks++; if ({rsp1_valid, rsp0_valid} !== (p == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL wrap_route[%0d]: got %b want %b", k, {rsp1_valid, rsp0_valid}, (p == 1 ? 2'b10 : 2'b01)); end
        checks++; if ((p == 1 ? rsp1_data : rsp0_data) !== 32'hC0 + 32'(k - 3)) begin errors++; $display("FAIL wrap_data[%0d]: got %h", k, (p == 1 ? rsp1_data : rsp0_data)); end
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; cache_valid_i = 1'b0;
    #1;
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b want 0", cache_ready_o); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wrap_no_err: got %b want 0", rsp_err); end
    step();
  endtask

  task automatic test_err_and_reset();
    do_reset();
    cache_valid_i = 1'b1; cache_data = 32'hDEAD;
    #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL err_no_rsp: got %b want 00", {rsp1_valid, rsp0_valid}); end
    step();
    cache_valid_i = 1'b0;
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", rsp_err); end
    step();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", rsp_err); end
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL err_no_pop: got %b want 0", cache_ready_o); end
    cache_ready_i = 1'b0;
    req0_valid = 1'b1; req0_pkt = mkpkt(32'h700, 32'h0, 1'b0);
    step();
    req0_valid = 1'b0;
    checks++; if (cache_valid_o !== 1'b1) begin errors++; $display("FAIL mid_stage_full: got %b want 1", cache_valid_o); end
    checks++; if (cache_ready_o !== 1'b1) begin errors++; $display("FAIL mid_tag_pushed: got %b want 1", cache_ready_o); end
    rst = 1'b1;
    cache_ready_i = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 0", req0_ready); end
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    #1;
    checks++; if (cache_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid_cleared: got %b want 0", cache_valid_o); end
    checks++; if (cache_ready_o !== 1'b0) begin errors++; $display("FAIL mid_tags_cleared: got %b want 0", cache_ready_o); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_err_cleared: got %b want 0", rsp_err); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_writes();
    test_round_robin();
    test_backpressure();
    test_rd_block();
    test_wrap();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
